// File: rtl/branch_resolve_unit.sv
// Branch resolution for the gshare predictor: evaluates EX branches, registers the
// outcome into a MEM slot, drives the predictor update and redirects/flushes on mispredict.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_branch,
  input  logic [2:0]           ex_funct3,
  input  logic [31:0]          ex_rs1,
  input  logic [31:0]          ex_rs2,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_imm,
  input  logic                 ex_pred_taken,
  input  logic [2:0]           ex_pht_index,
  input  logic                 stall,
  output logic                 branch_resolved,
  output logic                 actual_taken,
  output logic [2:0]           pht_indexMEM,
  output logic                 mispredict,
  output logic [31:0]          PC_redirect,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [3:0]  flush_cnt;

  logic        vld_p0, taken_p0;
  logic [31:0] target_p0, fall_p0, redirect_p0;

  logic        vld_p1, fresh_p1, taken_p1, pred_p1;
  logic [2:0]  idx_p1;
  logic [31:0] redirect_p1;

  function automatic logic br_legal(input logic [2:0] f3);
    br_legal = (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = signed'(a);
    sb = signed'(b);
    case (f3)
      3'b000:  br_cond = (a == b);
      3'b001:  br_cond = (a != b);
      3'b100:  br_cond = (sa < sb);
      3'b101:  br_cond = (sa >= sb);
      3'b110:  br_cond = (a < b);
      3'b111:  br_cond = (a >= b);
      default: br_cond = 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  // ---- Stage p0: EX evaluation and acceptance ----
  // Branches in EX are squashed while flushing and in the mispredict cycle itself.
  assign taken_p0    = br_cond(ex_funct3, ex_rs1, ex_rs2);
  assign target_p0   = ex_pc + ex_imm;
  assign fall_p0     = ex_pc + 32'd4;
  assign redirect_p0 = taken_p0 ? target_p0 : fall_p0;
  assign vld_p0      = ex_valid && ex_branch && br_legal(ex_funct3) && !stall &&
                       (state == IDLE) && !mispredict;

  // ---- Stage p1: MEM slot ----
  // fresh_p1 drops after one cycle even when stall holds the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      fresh_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1   <= vld_p0;
      fresh_p1 <= vld_p0;
    end else begin
      fresh_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && vld_p0) begin
      taken_p1    <= taken_p0;
      pred_p1     <= ex_pred_taken;
      idx_p1      <= ex_pht_index;
      redirect_p1 <= redirect_p0;
    end
  end

  assign branch_resolved = fresh_p1;
  assign actual_taken    = vld_p1 & taken_p1;
  assign pht_indexMEM    = vld_p1 ? idx_p1 : 3'd0;
  assign mispredict      = fresh_p1 && (pred_p1 != taken_p1);
  assign PC_redirect     = mispredict ? redirect_p1 : 32'd0;

  // ---- Flush sequencer ----
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mispredict) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flush = (state == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst)                             flush_cnt <= 4'd0;
    else if (state == IDLE && mispredict) flush_cnt <= FLUSH_LOAD;
    else if (state == FLUSH)             flush_cnt <= flush_cnt - 4'd1;
  end

  // ---- Performance counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (fresh_p1)   branch_count     <= sat_inc(branch_count);
      if (mispredict) mispredict_count <= sat_inc(mispredict_count);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand-written multi-cycle
// sequences and a randomized run checked each cycle against a behavioural model.
module tb_branch_resolve_unit;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk, rst;
  logic          ex_valid, ex_branch, ex_pred_taken, stall;
  logic [2:0]    ex_funct3, ex_pht_index;
  logic [31:0]   ex_rs1, ex_rs2, ex_pc, ex_imm;
  logic          branch_resolved, actual_taken, mispredict, flush;
  logic [2:0]    pht_indexMEM;
  logic [31:0]   PC_redirect;
  logic [CW-1:0] branch_count, mispredict_count;

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken), .ex_pht_index(ex_pht_index),
    .stall(stall), .branch_resolved(branch_resolved), .actual_taken(actual_taken),
    .pht_indexMEM(pht_indexMEM), .mispredict(mispredict), .PC_redirect(PC_redirect),
    .flush(flush), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one pending entry, a flush countdown and two counters.
  bit          m_vld, m_fresh, m_taken, m_pred;
  bit [2:0]    m_idx;
  bit [31:0]   m_redir;
  int          m_flush_left, m_bc, m_mc;

  function automatic bit ref_taken(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    bit mis, acc, t;
    mis = m_fresh && (m_pred != m_taken);
    acc = ex_valid && ex_branch && (ex_funct3 != 3'd2) && (ex_funct3 != 3'd3) &&
          !stall && (m_flush_left == 0) && !mis;
    if (rst) begin
      m_vld = 0; m_fresh = 0; m_taken = 0; m_pred = 0; m_idx = 0; m_redir = 0;
      m_flush_left = 0; m_bc = 0; m_mc = 0;
    end else begin
      if (m_fresh && m_bc < MAXC) m_bc++;
      if (mis && m_mc < MAXC) m_mc++;
      if (mis) m_flush_left = FC;
      else if (m_flush_left > 0) m_flush_left--;
      if (stall) m_fresh = 0;
      else if (acc) begin
        t = ref_taken(ex_funct3, ex_rs1, ex_rs2);
        m_vld = 1; m_fresh = 1; m_taken = t; m_pred = ex_pred_taken; m_idx = ex_pht_index;
        if (ex_pred_taken && !t)      m_redir = ex_pc + 32'd4;
        else if (!ex_pred_taken && t) m_redir = ex_pc + ex_imm;
        else                          m_redir = 32'd0;
      end else begin
        m_vld = 0; m_fresh = 0;
      end
    end
  endtask

  task automatic check_all();
    bit exp_mis;
    exp_mis = m_fresh && (m_pred != m_taken);
    chk("branch_resolved", 32'(branch_resolved), 32'(m_fresh));
    chk("actual_taken", 32'(actual_taken), 32'(m_vld && m_taken));
    chk("pht_indexMEM", 32'(pht_indexMEM), m_vld ? 32'(m_idx) : 32'd0);
    chk("mispredict", 32'(mispredict), 32'(exp_mis));
    chk("PC_redirect", PC_redirect, exp_mis ? m_redir : 32'd0);
    chk("flush", 32'(flush), 32'(m_flush_left > 0));
    chk("branch_count", 32'(branch_count), 32'(m_bc));
    chk("mispredict_count", 32'(mispredict_count), 32'(m_mc));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_idle();
    ex_valid = 0; ex_branch = 0; ex_funct3 = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_pc = 0; ex_imm = 0; ex_pred_taken = 0; ex_pht_index = 0; stall = 0;
  endtask

  task automatic present(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b,
                         input bit [31:0] pc, input bit [31:0] imm, input bit pred,
                         input bit [2:0] idx);
    ex_valid = 1; ex_branch = 1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = pred; ex_pht_index = idx; stall = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  typedef struct {
    bit [2:0]  f3;
    bit [31:0] rs1, rs2, pc, imm;
    bit        pred;
    bit [2:0]  idx;
    bit        e_res, e_taken, e_mis;
    bit [31:0] e_redir;
  } vec_t;

  vec_t vecs[11];
  int   fl_seen, res_seen;

  initial begin
    vecs[0]  = '{3'd0, 32'h5, 32'h5, 32'h40, 32'h10, 1, 3'd3, 1, 1, 0, 32'h0};
    vecs[1]  = '{3'd1, 32'h7, 32'h7, 32'h100, 32'h40, 1, 3'd1, 1, 0, 1, 32'h104};
    vecs[2]  = '{3'd4, 32'hFFFFFFFF, 32'h1, 32'h300, 32'h20, 1, 3'd2, 1, 1, 0, 32'h0};
    vecs[3]  = '{3'd6, 32'hFFFFFFFF, 32'h1, 32'h300, 32'h20, 0, 3'd2, 1, 0, 0, 32'h0};
    vecs[4]  = '{3'd4, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0, 0, 3'd4, 1, 1, 1, 32'h1F0};
    vecs[5]  = '{3'd7, 32'h5, 32'h5, 32'hFFFFFFFC, 32'h8, 0, 3'd5, 1, 1, 1, 32'h4};
    vecs[6]  = '{3'd7, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h8, 1, 3'd6, 1, 0, 1, 32'h0};
    vecs[7]  = '{3'd5, 32'h80000000, 32'h0, 32'h10, 32'h8, 0, 3'd7, 1, 0, 0, 32'h0};
    vecs[8]  = '{3'd2, 32'h5, 32'h5, 32'h10, 32'h8, 1, 3'd1, 0, 0, 0, 32'h0};
    vecs[9]  = '{3'd1, 32'h1, 32'h2, 32'h1000, 32'h100, 0, 3'd0, 1, 1, 1, 32'h1100};
    vecs[10] = '{3'd5, 32'h3, 32'h3, 32'h0, 32'h4, 1, 3'd7, 1, 1, 0, 32'h0};

    set_idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    chk("reset_resolved", 32'(branch_resolved), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    chk("reset_bc", 32'(branch_count), 32'd0);
    chk("reset_mc", 32'(mispredict_count), 32'd0);

    // Mispredicted BNE, then a BEQ held in EX through the flush window.
    present(3'd1, 32'h7, 32'h7, 32'h100, 32'h40, 1, 3'd1);
    cycle();
    chk("seqA_mis", 32'(mispredict), 32'd1);
    chk("seqA_redirect", PC_redirect, 32'h104);
    present(3'd0, 32'h5, 32'h5, 32'h80, 32'h10, 1, 3'd2);
    fl_seen = 0; res_seen = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      fl_seen += int'(flush);
      res_seen += int'(branch_resolved);
    end
    set_idle();
    chk("seqA_flush_cycles", 32'(fl_seen), 32'(FC));
    chk("seqA_squashed", 32'(res_seen), 32'd0);
    chk("seqA_mc", 32'(mispredict_count), 32'd1);
    chk("seqA_bc", 32'(branch_count), 32'd1);

    // Accepted branch then stall held for three cycles.
    do_reset();
    present(3'd0, 32'h9, 32'h9, 32'h20, 32'h8, 1, 3'd2);
    cycle();
    set_idle();
    stall = 1;
    chk("seqB_res0", 32'(branch_resolved), 32'd1);
    chk("seqB_tk0", 32'(actual_taken), 32'd1);
    for (int k = 1; k < 3; k++) begin
      cycle();
      chk($sformatf("seqB_res%0d", k), 32'(branch_resolved), 32'd0);
      chk($sformatf("seqB_tk%0d", k), 32'(actual_taken), 32'd1);
      chk($sformatf("seqB_idx%0d", k), 32'(pht_indexMEM), 32'd2);
    end
    stall = 0;
    cycle();
    chk("seqB_bc", 32'(branch_count), 32'd1);
    chk("seqB_empty", 32'(actual_taken), 32'd0);

    // Reset in the first flush cycle.
    do_reset();
    present(3'd1, 32'h7, 32'h7, 32'h100, 32'h40, 1, 3'd1);
    cycle();
    set_idle();
    cycle();
    chk("seqC_flush_on", 32'(flush), 32'd1);
    rst = 1;
    cycle();
    rst = 0;
    chk("seqC_flush_off", 32'(flush), 32'd0);
    chk("seqC_bc", 32'(branch_count), 32'd0);
    chk("seqC_mc", 32'(mispredict_count), 32'd0);
    chk("seqC_res", 32'(branch_resolved), 32'd0);
    cycle();
    chk("seqC_no_pending", 32'(branch_resolved), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      present(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm,
              vecs[i].pred, vecs[i].idx);
      cycle();
      set_idle();
      chk($sformatf("vec%0d_resolved", i), 32'(branch_resolved), 32'(vecs[i].e_res));
      chk($sformatf("vec%0d_taken", i), 32'(actual_taken), 32'(vecs[i].e_taken));
      chk($sformatf("vec%0d_mis", i), 32'(mispredict), 32'(vecs[i].e_mis));
      chk($sformatf("vec%0d_redirect", i), PC_redirect, vecs[i].e_redir);
      chk($sformatf("vec%0d_idx", i), 32'(pht_indexMEM), vecs[i].e_res ? 32'(vecs[i].idx) : 32'd0);
      repeat (FC + 1) cycle();
    end

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 399) == 0);
      ex_valid      = ($urandom_range(0, 9) < 8);
      ex_branch     = ($urandom_range(0, 9) < 7);
      ex_funct3     = 3'($urandom_range(0, 7));
      ex_rs1        = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      ex_rs2        = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      ex_pc         = $urandom;
      ex_imm        = $urandom;
      ex_pred_taken = 1'($urandom_range(0, 1));
      ex_pht_index  = 3'($urandom_range(0, 7));
      stall         = ($urandom_range(0, 3) == 0);
      cycle();
    end
    rst = 0;
    set_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
